lsu: RTL and testbench

//  Load/store unit directly downstream of the ALU. It takes alu_out as the effective byte address and

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_if.sv | 26 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu.sv | 108 ++++++++++
 tb/tb_lsu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: access-size codes, FSM encoding and byte-lane count.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store-data replication with byte enables, and load lane
// selection with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_lane,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [BE_W-1:0] st_be,
  input  logic [2:0]      ld_f3,
  input  logic [1:0]      ld_lane,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_size)
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_lane;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = 4'b0011 << {st_lane[1], 1'b0};
      end
      default: ;
    endcase
  end

  // funct3[2] marks the unsigned variants
  always_comb begin
    w_byte  = ld_rdata[{ld_lane, 3'b000} +: 8];
    w_half  = ld_rdata[{ld_lane[1], 4'b0000} +: 16];
    w_sext  = ~ld_f3[2];
    ld_data = ld_rdata;
    case (ld_f3[1:0])
      2'b00:   ld_data = {{24{w_byte[7] & w_sext}}, w_byte};
      2'b01:   ld_data = {{16{w_half[15] & w_sext}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one req/gnt/rvalid memory access per load/store and stalls the
// single-cycle core until the access retires in DONE.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [XLEN-1:0]   store_data,
  input  logic [2:0]        funct3,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              stall,
  output logic              lsu_err,
  output logic [XLEN-1:0]   load_data,
  lsu_if.master             bus
);
  state_t            r_state, w_state_next;
  logic              w_access, w_start;
  logic              r_mem_req, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata, r_load_data;
  logic [BE_W-1:0]   r_mem_be;
  logic [1:0]        r_lane;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   w_st_wdata, w_ld_data;
  logic [BE_W-1:0]   w_st_be;

  assign w_access = mem_read ^ mem_write;
  assign lsu_err  = (mem_read & mem_write)
                  | (w_access & (f3_illegal(funct3)
                               | (mem_write & funct3[2])
                               | ((funct3[1:0] == 2'b01) & alu_out[0])
                               | ((funct3[1:0] == 2'b10) & (alu_out[1:0] != 2'b00))));
  assign w_start  = (r_state == IDLE) & w_access & ~lsu_err;

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_size  (funct3[1:0]),
    .st_lane  (alu_out[1:0]),
    .st_data  (store_data),
    .st_wdata (w_st_wdata),
    .st_be    (w_st_be),
    .ld_f3    (r_funct3),
    .ld_lane  (r_lane),
    .ld_rdata (bus.mem_rdata),
    .ld_data  (w_ld_data)
  );

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = REQ;
          stall        = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.mem_gnt) w_state_next = r_mem_we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.mem_rvalid) w_state_next = DONE;
      end
      DONE: w_state_next = IDLE;
    endcase
  end

  // Core inputs are only sampled on the IDLE->REQ transition; later stages use the latched copy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_lane      <= '0;
      r_funct3    <= '0;
      r_load_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_mem_req <= (w_state_next == REQ);
      if (w_start) begin
        r_mem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
        r_mem_we    <= mem_write;
        r_mem_wdata <= w_st_wdata;
        r_mem_be    <= w_st_be;
        r_lane      <= alu_out[1:0];
        r_funct3    <= funct3;
      end
      if ((r_state == WAIT) && bus.mem_rvalid) r_load_data <= w_ld_data;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign load_data     = r_load_data;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected bus beats and retirements, a monitor
// pops and compares them as the DUT presents handshakes and DONE cycles.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic        stall;
  logic        lsu_err;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

  lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_out    (alu_out),
    .store_data (store_data),
    .funct3     (funct3),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .stall      (stall),
    .lsu_err    (lsu_err),
    .load_data  (load_data),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
  } ret_t;

  bus_t exp_bus[$];
  ret_t exp_ret[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every granted request and every retirement against the queues
  logic prev_stall = 1'b0;
  bus_t mon_b;
  ret_t mon_r;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.mem_req) begin
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL spurious_req: mem_req=1 with no access outstanding, expected 0");
        end else if (bus.mem_gnt) begin
          mon_b = exp_bus.pop_front();
          check("bus_addr", bus.mem_addr, mon_b.addr);
          check("bus_we", {31'd0, bus.mem_we}, {31'd0, mon_b.we});
          check("bus_be", {28'd0, bus.mem_be}, {28'd0, mon_b.be});
          if (mon_b.we) check("bus_wdata", bus.mem_wdata, mon_b.wdata);
          $display("bus beat addr=0x%08h we=%0b be=%04b wdata=0x%08h",
                   bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata);
        end
      end
      if (prev_stall && !stall) begin
        checks++;
        if (exp_ret.size() == 0) begin
          errors++;
          $display("FAIL spurious_retire: DONE cycle with no access outstanding, expected none");
        end else begin
          mon_r = exp_ret.pop_front();
          if (mon_r.is_load) check("load_data", load_data, mon_r.data);
          $display("retire load=%0b load_data=0x%08h", mon_r.is_load, load_data);
        end
      end
      prev_stall = stall;
    end
  end

  task automatic idle_inputs();
    alu_out    = '0;
    store_data = '0;
    funct3     = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
  endtask

  task automatic do_access(input string name, input logic ld, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [2:0] f3, input int gnt_delay,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_ld);
    bus_t b;
    ret_t r;
    int   stalls = 0;
    int   reqs = 0;
    int   cyc = 0;
    bit   rv_pend = 1'b0;
    bit   done = 1'b0;
    b.addr = exp_addr; b.we = ~ld; b.be = exp_be; b.wdata = exp_wdata;
    r.is_load = ld; r.data = exp_ld;
    exp_bus.push_back(b);
    exp_ret.push_back(r);
    @(posedge clk); #1;
    alu_out = addr; store_data = sd; funct3 = f3;
    mem_read = ld; mem_write = ~ld; bus.mem_rdata = rdata;
    while (!done && cyc < 40) begin
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rv_pend) begin
        bus.mem_rvalid = 1'b1;
        rv_pend = 1'b0;
      end else if (bus.mem_req) begin
        if (reqs == gnt_delay) begin
          bus.mem_gnt = 1'b1;
          rv_pend = ld;
        end
        reqs++;
      end
      @(negedge clk);
      if (cyc == 0) check({name, "_err"}, {31'd0, lsu_err}, 32'd0);
      if (stall) stalls++;
      else done = 1'b1;
      cyc++;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_stall_cycles"}, stalls, ld ? 32'(3 + gnt_delay) : 32'(2 + gnt_delay));
    $display("access %s addr=0x%08h stall_cycles=%0d", name, addr, stalls);
  endtask

  task automatic do_err(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [2:0] f3);
    @(posedge clk); #1;
    alu_out = addr; store_data = 32'hA5A5A5A5; funct3 = f3;
    mem_read = rd; mem_write = wr;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check({name, "_err"}, {31'd0, lsu_err}, 32'd1);
    check({name, "_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_no_req"}, {31'd0, bus.mem_req}, 32'd0);
    $display("error access %s lsu_err=%0b stall=%0b", name, lsu_err, stall);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //        name    ld   addr          sd            f3     dly rdata         exp_addr      be       wdata         load
    do_access("LW",   1, 32'h0000_0100, 32'h0,        F3_W,  0, 32'hDEADBEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEADBEEF);
    do_access("LB",   1, 32'h0000_0103, 32'h0,        F3_B,  0, 32'h80FF0000, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFFFF80);
    do_access("LBU",  1, 32'h0000_0103, 32'h0,        F3_BU, 1, 32'h80FF0000, 32'h0000_0100, 4'b1000, 32'h0,        32'h00000080);
    do_access("LHU",  1, 32'h0000_0102, 32'h0,        F3_HU, 0, 32'h80FF0000, 32'h0000_0100, 4'b1100, 32'h0,        32'h000080FF);
    do_access("LH",   1, 32'h0000_0102, 32'h0,        F3_H,  2, 32'h80FF0000, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF80FF);
    do_access("LB1",  1, 32'h0000_0101, 32'h0,        F3_B,  0, 32'h00007F00, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000007F);
    do_access("LH0",  1, 32'h0000_0100, 32'h0,        F3_H,  0, 32'h12348001, 32'h0000_0100, 4'b0011, 32'h0,        32'hFFFF8001);
    do_access("SB",   0, 32'h0000_0201, 32'h12345678, F3_B,  3, 32'h0,        32'h0000_0200, 4'b0010, 32'h78787878, 32'h0);
    do_access("SH",   0, 32'h0000_0202, 32'hCAFEBABE, F3_H,  0, 32'h0,        32'h0000_0200, 4'b1100, 32'hBABEBABE, 32'h0);
    do_access("SW1",  0, 32'h0000_0204, 32'h11223344, F3_W,  0, 32'h0,        32'h0000_0204, 4'b1111, 32'h11223344, 32'h0);
    do_access("SW2",  0, 32'h0000_0208, 32'h55667788, F3_W,  0, 32'h0,        32'h0000_0208, 4'b1111, 32'h55667788, 32'h0);

    do_err("LW_mis", 1'b1, 1'b0, 32'h0000_0102, F3_W);
    do_err("SH_mis", 1'b0, 1'b1, 32'h0000_0101, F3_H);
    do_err("F3_011", 1'b1, 1'b0, 32'h0000_0100, 3'b011);
    do_err("RD_WR",  1'b1, 1'b1, 32'h0000_0100, F3_W);
    do_err("SBU",    1'b0, 1'b1, 32'h0000_0200, F3_BU);

    // Reset while waiting for read data: the late rvalid must not complete the load
    begin
      bus_t b;
      b.addr = 32'h0000_0300; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'h0;
      exp_bus.push_back(b);
      @(posedge clk); #1;
      alu_out = 32'h0000_0300; funct3 = F3_W; mem_read = 1'b1; mem_write = 1'b0;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      idle_inputs();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'h55555555;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      check("wait_rst_load_data", load_data, 32'd0);
      check("wait_rst_stall", {31'd0, stall}, 32'd0);
      check("wait_rst_req", {31'd0, bus.mem_req}, 32'd0);
      check("wait_rst_addr", bus.mem_addr, 32'd0);
      $display("reset in WAIT load_data=0x%08h stall=%0b", load_data, stall);
    end

    do_access("LW_after", 1, 32'h0000_0104, 32'h0, F3_W, 0, 32'hA5A5A5A5, 32'h0000_0104, 4'b1111, 32'h0, 32'hA5A5A5A5);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bus_queue_empty", exp_bus.size(), 32'd0);
    check("retire_queue_empty", exp_ret.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
